// File: rtl/xif_coproc_arbiter.sv
// Shares one XIF coprocessor between NUM_REQ cores: round-robin issue arbitration with source
// tagging, per-core commit FIFOs drained round-robin, and tag-routed result return.
module xif_coproc_arbiter #(
    parameter  int unsigned NUM_REQ  = 2,
    parameter  int unsigned ID_W     = 4,
    parameter  int unsigned ISSUE_W  = 64,
    parameter  int unsigned RESULT_W = 40,
    parameter  int unsigned MAX_OUT  = 4,
    localparam int unsigned SRC_W    = $clog2(NUM_REQ)
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [NUM_REQ-1:0]          req_issue_valid_i,
    output logic [NUM_REQ-1:0]          req_issue_ready_o,
    input  logic [NUM_REQ*ID_W-1:0]     req_issue_id_i,
    input  logic [NUM_REQ*ISSUE_W-1:0]  req_issue_payload_i,
    output logic [NUM_REQ-1:0]          req_issue_accept_o,
    input  logic [NUM_REQ-1:0]          req_commit_valid_i,
    input  logic [NUM_REQ*ID_W-1:0]     req_commit_id_i,
    input  logic [NUM_REQ-1:0]          req_commit_kill_i,
    output logic [NUM_REQ-1:0]          req_result_valid_o,
    input  logic [NUM_REQ-1:0]          req_result_ready_i,
    output logic [ID_W-1:0]             req_result_id_o,
    output logic [RESULT_W-1:0]         req_result_payload_o,
    output logic                        cop_issue_valid_o,
    input  logic                        cop_issue_ready_i,
    output logic [SRC_W+ID_W-1:0]       cop_issue_id_o,
    output logic [ISSUE_W-1:0]          cop_issue_payload_o,
    input  logic                        cop_issue_accept_i,
    output logic                        cop_commit_valid_o,
    output logic [SRC_W+ID_W-1:0]       cop_commit_id_o,
    output logic                        cop_commit_kill_o,
    input  logic                        cop_result_valid_i,
    output logic                        cop_result_ready_o,
    input  logic [SRC_W+ID_W-1:0]       cop_result_id_i,
    input  logic [RESULT_W-1:0]         cop_result_payload_i
);

    localparam int unsigned CNT_W = $clog2(MAX_OUT + 1);
    localparam int unsigned PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int unsigned CM_W  = ID_W + 1;

    typedef enum logic [0:0] {StIdle, StHold} state_e;

    state_e             state_q, state_d;
    logic [SRC_W-1:0]   grant_q, grant_d;
    logic [SRC_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [SRC_W-1:0]   cm_ptr_q, cm_ptr_d;
    logic [CNT_W-1:0]   out_cnt_q [NUM_REQ];
    logic [CNT_W-1:0]   out_cnt_d [NUM_REQ];
    logic [CNT_W-1:0]   fifo_cnt_q [NUM_REQ];
    logic [CNT_W-1:0]   fifo_cnt_d [NUM_REQ];
    logic [PTR_W-1:0]   wr_ptr_q [NUM_REQ];
    logic [PTR_W-1:0]   wr_ptr_d [NUM_REQ];
    logic [PTR_W-1:0]   rd_ptr_q [NUM_REQ];
    logic [PTR_W-1:0]   rd_ptr_d [NUM_REQ];
    logic [CM_W-1:0]    fifo_mem_q [NUM_REQ][MAX_OUT];
    logic [CM_W-1:0]    fifo_mem_d [NUM_REQ][MAX_OUT];

    logic [NUM_REQ-1:0] eligible, nonempty;
    logic [NUM_REQ-1:0] cnt_inc, cnt_dec_r, cnt_dec_k, fifo_pop;
    logic               pick_found, cm_found, issue_valid, issue_hs, res_hs, res_in_range;
    logic [SRC_W-1:0]   pick_idx, cm_sel, gnt, res_src;
    logic [CM_W-1:0]    cm_head;

    function automatic logic [SRC_W-1:0] src_inc(input logic [SRC_W-1:0] v);
        return (v == SRC_W'(NUM_REQ - 1)) ? '0 : v + 1'b1;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] v);
        return (v == PTR_W'(MAX_OUT - 1)) ? '0 : v + 1'b1;
    endfunction

    // Returns {found, index} of the first set request at or after ptr, wrapping.
    function automatic logic [SRC_W:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [SRC_W-1:0]   ptr);
        logic [SRC_W-1:0] idx;
        logic [SRC_W:0]   res;
        idx = ptr;
        res = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!res[SRC_W] && req[idx]) res = {1'b1, idx};
            idx = src_inc(idx);
        end
        return res;
    endfunction

    assign res_src = cop_result_id_i[SRC_W+ID_W-1 -: SRC_W];

    if (NUM_REQ == (1 << SRC_W)) begin : g_pow2
        assign res_in_range = 1'b1;
    end else begin : g_npow2
        assign res_in_range = (32'(res_src) < NUM_REQ);
        a_res_src_range: assert property (@(posedge clk_i) disable iff (rst_i)
            cop_result_valid_i |-> res_in_range);
    end

    always_comb begin
        state_d            = state_q;
        grant_d            = grant_q;
        rr_ptr_d           = rr_ptr_q;
        cm_ptr_d           = cm_ptr_q;
        out_cnt_d          = out_cnt_q;
        fifo_cnt_d         = fifo_cnt_q;
        wr_ptr_d           = wr_ptr_q;
        rd_ptr_d           = rd_ptr_q;
        fifo_mem_d         = fifo_mem_q;
        issue_valid        = 1'b0;
        gnt                = grant_q;
        req_issue_ready_o  = '0;
        req_issue_accept_o = '0;
        req_result_valid_o = '0;
        cnt_inc            = '0;
        cnt_dec_r          = '0;
        cnt_dec_k          = '0;
        fifo_pop           = '0;

        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            eligible[i] = req_issue_valid_i[i] && (out_cnt_q[i] < CNT_W'(MAX_OUT));
            nonempty[i] = (fifo_cnt_q[i] != '0);
        end
        {pick_found, pick_idx} = rr_pick(eligible, rr_ptr_q);
        {cm_found, cm_sel}     = rr_pick(nonempty, cm_ptr_q);

        case (state_q)
            StIdle: begin
                if (pick_found) begin
                    issue_valid = 1'b1;
                    gnt         = pick_idx;
                    grant_d     = pick_idx;
                    state_d     = StHold;
                end
            end
            StHold:  issue_valid = 1'b1;
            default: state_d = StIdle;
        endcase

        issue_hs = issue_valid && cop_issue_ready_i;
        if (issue_hs) begin
            req_issue_ready_o[gnt]  = ~rst_i;
            req_issue_accept_o[gnt] = cop_issue_accept_i & ~rst_i;
            rr_ptr_d                = src_inc(gnt);
            state_d                 = StIdle;
        end
        cop_issue_valid_o   = issue_valid & ~rst_i;
        cop_issue_id_o      = {gnt, req_issue_id_i[gnt*ID_W +: ID_W]};
        cop_issue_payload_o = req_issue_payload_i[gnt*ISSUE_W +: ISSUE_W];

        // Commit head is read straight from FIFO storage, so a push is visible next cycle.
        cm_head            = fifo_mem_q[cm_sel][rd_ptr_q[cm_sel]];
        cop_commit_valid_o = cm_found;
        cop_commit_id_o    = {cm_sel, cm_head[ID_W-1:0]};
        cop_commit_kill_o  = cm_head[ID_W];
        if (cm_found) cm_ptr_d = src_inc(cm_sel);

        if (res_in_range) req_result_valid_o[res_src] = cop_result_valid_i & ~rst_i;
        cop_result_ready_o   = ~rst_i & (res_in_range ? req_result_ready_i[res_src] : 1'b1);
        req_result_id_o      = cop_result_id_i[ID_W-1:0];
        req_result_payload_o = cop_result_payload_i;
        res_hs               = cop_result_valid_i && cop_result_ready_o && res_in_range;

        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            fifo_pop[i]  = cm_found && (cm_sel == SRC_W'(i));
            cnt_inc[i]   = issue_hs && cop_issue_accept_i && (gnt == SRC_W'(i));
            cnt_dec_r[i] = res_hs && (res_src == SRC_W'(i));
            cnt_dec_k[i] = fifo_pop[i] && cm_head[ID_W];
            out_cnt_d[i] = out_cnt_q[i] + CNT_W'(cnt_inc[i]) - CNT_W'(cnt_dec_r[i])
                         - CNT_W'(cnt_dec_k[i]);
            if (req_commit_valid_i[i]) begin
                fifo_mem_d[i][wr_ptr_q[i]] = {req_commit_kill_i[i], req_commit_id_i[i*ID_W +: ID_W]};
                wr_ptr_d[i] = ptr_inc(wr_ptr_q[i]);
            end
            if (fifo_pop[i]) rd_ptr_d[i] = ptr_inc(rd_ptr_q[i]);
            fifo_cnt_d[i] = fifo_cnt_q[i] + CNT_W'(req_commit_valid_i[i]) - CNT_W'(fifo_pop[i]);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            cm_ptr_q <= '0;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                out_cnt_q[i]  <= '0;
                fifo_cnt_q[i] <= '0;
                wr_ptr_q[i]   <= '0;
                rd_ptr_q[i]   <= '0;
                for (int unsigned j = 0; j < MAX_OUT; j++) fifo_mem_q[i][j] <= '0;
            end
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            cm_ptr_q   <= cm_ptr_d;
            out_cnt_q  <= out_cnt_d;
            fifo_cnt_q <= fifo_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_mem_q <= fifo_mem_d;
        end
    end

    a_hold_valid: assert property (@(posedge clk_i) disable iff (rst_i)
        (state_q == StHold) |-> req_issue_valid_i[grant_q]);

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_chk
        a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
            ((CNT_W+1)'(cnt_dec_r[gi]) + (CNT_W+1)'(cnt_dec_k[gi])) <=
            (CNT_W+1)'(out_cnt_q[gi]));
        a_fifo_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
            req_commit_valid_i[gi] |-> ((fifo_cnt_q[gi] != CNT_W'(MAX_OUT)) || fifo_pop[gi]));
    end

endmodule

// File: tb/tb_xif_coproc_arbiter.sv
// Directed self-checking bench for xif_coproc_arbiter (2 cores, 4 outstanding each).
module tb_xif_coproc_arbiter;

    localparam int unsigned NUM_REQ  = 2;
    localparam int unsigned ID_W     = 4;
    localparam int unsigned ISSUE_W  = 64;
    localparam int unsigned RESULT_W = 40;
    localparam int unsigned MAX_OUT  = 4;
    localparam int unsigned SRC_W    = 1;

    localparam logic [ISSUE_W-1:0] PAY0 = 64'h1111_2222_3333_4444;
    localparam logic [ISSUE_W-1:0] PAY1 = 64'h5555_6666_7777_8888;

    logic                        clk = 1'b0;
    logic                        rst;
    logic [NUM_REQ-1:0]          req_issue_valid;
    logic [NUM_REQ-1:0]          req_issue_ready;
    logic [NUM_REQ*ID_W-1:0]     req_issue_id;
    logic [NUM_REQ*ISSUE_W-1:0]  req_issue_payload;
    logic [NUM_REQ-1:0]          req_issue_accept;
    logic [NUM_REQ-1:0]          req_commit_valid;
    logic [NUM_REQ*ID_W-1:0]     req_commit_id;
    logic [NUM_REQ-1:0]          req_commit_kill;
    logic [NUM_REQ-1:0]          req_result_valid;
    logic [NUM_REQ-1:0]          req_result_ready;
    logic [ID_W-1:0]             req_result_id;
    logic [RESULT_W-1:0]         req_result_payload;
    logic                        cop_issue_valid;
    logic                        cop_issue_ready;
    logic [SRC_W+ID_W-1:0]       cop_issue_id;
    logic [ISSUE_W-1:0]          cop_issue_payload;
    logic                        cop_issue_accept;
    logic                        cop_commit_valid;
    logic [SRC_W+ID_W-1:0]       cop_commit_id;
    logic                        cop_commit_kill;
    logic                        cop_result_valid;
    logic                        cop_result_ready;
    logic [SRC_W+ID_W-1:0]       cop_result_id;
    logic [RESULT_W-1:0]         cop_result_payload;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    xif_coproc_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W),
        .ISSUE_W (ISSUE_W),
        .RESULT_W(RESULT_W),
        .MAX_OUT (MAX_OUT)
    ) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .req_issue_valid_i   (req_issue_valid),
        .req_issue_ready_o   (req_issue_ready),
        .req_issue_id_i      (req_issue_id),
        .req_issue_payload_i (req_issue_payload),
        .req_issue_accept_o  (req_issue_accept),
        .req_commit_valid_i  (req_commit_valid),
        .req_commit_id_i     (req_commit_id),
        .req_commit_kill_i   (req_commit_kill),
        .req_result_valid_o  (req_result_valid),
        .req_result_ready_i  (req_result_ready),
        .req_result_id_o     (req_result_id),
        .req_result_payload_o(req_result_payload),
        .cop_issue_valid_o   (cop_issue_valid),
        .cop_issue_ready_i   (cop_issue_ready),
        .cop_issue_id_o      (cop_issue_id),
        .cop_issue_payload_o (cop_issue_payload),
        .cop_issue_accept_i  (cop_issue_accept),
        .cop_commit_valid_o  (cop_commit_valid),
        .cop_commit_id_o     (cop_commit_id),
        .cop_commit_kill_o   (cop_commit_kill),
        .cop_result_valid_i  (cop_result_valid),
        .cop_result_ready_o  (cop_result_ready),
        .cop_result_id_i     (cop_result_id),
        .cop_result_payload_i(cop_result_payload)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change just after a falling edge; outputs are sampled 2 time units later.
    initial begin
        rst                = 1'b1;
        req_issue_valid    = 2'b01;
        req_issue_id       = '0;
        req_issue_payload  = {PAY1, PAY0};
        req_commit_valid   = '0;
        req_commit_id      = '0;
        req_commit_kill    = '0;
        req_result_ready   = '0;
        cop_issue_ready    = 1'b1;
        cop_issue_accept   = 1'b1;
        cop_result_valid   = 1'b0;
        cop_result_id      = '0;
        cop_result_payload = '0;
        @(negedge clk);
        #2;
        check("rst_issue_valid", cop_issue_valid, 0);
        check("rst_issue_ready", req_issue_ready, 0);
        check("rst_commit_valid", cop_commit_valid, 0);
        check("rst_result_ready", cop_result_ready, 0);
        @(negedge clk);

        // First issue: core0 id 3, single-cycle handshake.
        rst          = 1'b0;
        req_issue_id = {4'h0, 4'h3};
        #2;
        check("first_valid", cop_issue_valid, 1);
        check("first_id", cop_issue_id, 5'h03);
        check("first_payload", cop_issue_payload, PAY0);
        check("first_ready", req_issue_ready, 2'b01);
        check("first_accept", req_issue_accept, 2'b01);
        @(negedge clk);

        // Both cores streaming: grants alternate starting at core1, until both hold 4.
        req_issue_valid = 2'b11;
        for (int k = 0; k < 7; k++) begin
            #2;
            check("alt_ready", req_issue_ready, (k % 2 == 0) ? 2'b10 : 2'b01);
            check("alt_src", cop_issue_id[4], (k % 2 == 0) ? 1 : 0);
            @(negedge clk);
        end
        #2;
        check("full_stall_valid", cop_issue_valid, 0);
        check("full_stall_ready", req_issue_ready, 0);
        @(negedge clk);

        // Result {1,7} to core1.
        req_issue_valid    = 2'b00;
        cop_result_valid   = 1'b1;
        cop_result_id      = 5'h17;
        cop_result_payload = 40'hAB_CDEF_0123;
        req_result_ready   = 2'b10;
        #2;
        check("res_valid", req_result_valid, 2'b10);
        check("res_id", req_result_id, 4'h7);
        check("res_payload", req_result_payload, 40'hAB_CDEF_0123);
        check("res_ready", cop_result_ready, 1);
        @(negedge clk);
        req_result_ready = 2'b01;
        #2;
        check("res_stall_ready", cop_result_ready, 0);
        check("res_stall_valid", req_result_valid, 2'b10);
        @(negedge clk);
        cop_result_valid = 1'b0;

        // Core1 (3 outstanding) granted and held while the coprocessor is not ready.
        req_issue_valid = 2'b11;
        req_issue_id    = {4'hA, 4'h1};
        cop_issue_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k == 2) begin
                cop_result_valid = 1'b1;
                cop_result_id    = 5'h01;
                req_result_ready = 2'b01;
            end else begin
                cop_result_valid = 1'b0;
            end
            #2;
            check("hold_valid", cop_issue_valid, 1);
            check("hold_id", cop_issue_id, 5'h1A);
            check("hold_payload", cop_issue_payload, PAY1);
            check("hold_ready", req_issue_ready, 0);
            if (k == 2) check("hold_res_valid", req_result_valid, 2'b01);
            @(negedge clk);
        end
        cop_result_valid = 1'b0;
        cop_issue_ready  = 1'b1;
        #2;
        check("hold_release_ready", req_issue_ready, 2'b10);
        check("hold_release_accept", req_issue_accept, 2'b10);
        check("hold_release_id", cop_issue_id, 5'h1A);
        @(negedge clk);
        #2;
        check("after_hold_grant", req_issue_ready, 2'b01);
        check("after_hold_src", cop_issue_id[4], 0);
        @(negedge clk);
        #2;
        check("stall2_valid", cop_issue_valid, 0);
        @(negedge clk);

        // Free a core0 slot, then a rejected issue must not consume it.
        req_issue_valid  = 2'b00;
        cop_result_valid = 1'b1;
        cop_result_id    = 5'h02;
        req_result_ready = 2'b01;
        @(negedge clk);
        cop_result_valid = 1'b0;
        req_issue_valid  = 2'b01;
        cop_issue_accept = 1'b0;
        #2;
        check("reject_ready", req_issue_ready, 2'b01);
        check("reject_accept", req_issue_accept, 2'b00);
        @(negedge clk);
        cop_issue_accept = 1'b1;
        #2;
        check("post_reject_ready", req_issue_ready, 2'b01);
        check("post_reject_accept", req_issue_accept, 2'b01);
        @(negedge clk);
        #2;
        check("stall3_valid", cop_issue_valid, 0);
        @(negedge clk);

        // Simultaneous commits from both cores drain on consecutive cycles.
        req_issue_valid  = 2'b00;
        req_commit_valid = 2'b11;
        req_commit_id    = {4'h5, 4'h2};
        req_commit_kill  = 2'b10;
        #2;
        check("commit_latency", cop_commit_valid, 0);
        @(negedge clk);
        req_commit_valid = 2'b00;
        #2;
        check("commit0_valid", cop_commit_valid, 1);
        check("commit0_id", cop_commit_id, 5'h02);
        check("commit0_kill", cop_commit_kill, 0);
        @(negedge clk);
        #2;
        check("commit1_valid", cop_commit_valid, 1);
        check("commit1_id", cop_commit_id, 5'h15);
        check("commit1_kill", cop_commit_kill, 1);
        @(negedge clk);
        #2;
        check("commit_idle", cop_commit_valid, 0);
        @(negedge clk);

        // Killed commit freed a core1 slot: grant and hold it, then reset mid-hold.
        req_issue_valid = 2'b10;
        req_issue_id    = {4'hB, 4'h9};
        cop_issue_ready = 1'b0;
        #2;
        check("kill_freed_valid", cop_issue_valid, 1);
        check("kill_freed_id", cop_issue_id, 5'h1B);
        @(negedge clk);
        #2;
        check("hold2_id", cop_issue_id, 5'h1B);
        cop_issue_ready = 1'b1;
        rst             = 1'b1;
        #1;
        check("async_rst_valid", cop_issue_valid, 0);
        check("async_rst_ready", req_issue_ready, 0);
        check("async_rst_commit", cop_commit_valid, 0);
        @(negedge clk);

        // After release every counter is zero: each core takes 4 issues, then stalls.
        rst             = 1'b0;
        req_issue_valid = 2'b01;
        for (int k = 0; k < 4; k++) begin
            #2;
            check("post_rst_c0_ready", req_issue_ready, 2'b01);
            check("post_rst_c0_id", cop_issue_id, 5'h09);
            @(negedge clk);
        end
        #2;
        check("post_rst_c0_stall", cop_issue_valid, 0);
        @(negedge clk);
        req_issue_valid = 2'b10;
        for (int k = 0; k < 4; k++) begin
            #2;
            check("post_rst_c1_ready", req_issue_ready, 2'b10);
            @(negedge clk);
        end
        #2;
        check("post_rst_c1_stall", cop_issue_valid, 0);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/xif_coproc_arbiter.md
Name: xif_coproc_arbiter

Overview:
- Shares one XIF coprocessor (e.g. fpu_ss) between NUM_REQ cores.
- Round-robin arbitrates the issue channel and tags each issued ID with the requester index.
- Serialises commits through per-requester FIFOs and routes results back by tag.
- Sits between the core-side XIF ports and the coprocessor wrapper. The memory channels are out of scope: the coprocessor is configured without load/store.

Parameters:
- NUM_REQ, 2, number of requesting cores (2..4).
- ID_W, 4, core-side instruction ID width.
- ISSUE_W, 64, opaque issue payload width (instr, rs, mode).
- RESULT_W, 40, opaque result payload width.
- MAX_OUT, 4, maximum in-flight instructions per requester; also the commit FIFO depth.
- Derived: SRC_W = $clog2(NUM_REQ).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- req_issue_valid_i  in  NUM_REQ  per-core issue valid
- req_issue_ready_o  out  NUM_REQ  per-core issue ready
- req_issue_id_i  in  NUM_REQ*ID_W  per-core issue ID
- req_issue_payload_i  in  NUM_REQ*ISSUE_W  per-core issue payload
- req_issue_accept_o  out  NUM_REQ  coprocessor accept, routed to the granted core
- req_commit_valid_i  in  NUM_REQ  per-core commit valid (no ready)
- req_commit_id_i  in  NUM_REQ*ID_W  commit ID
- req_commit_kill_i  in  NUM_REQ  commit kill flag
- req_result_valid_o  out  NUM_REQ  result valid, routed by tag
- req_result_ready_i  in  NUM_REQ  per-core result ready
- req_result_id_o  out  ID_W  result ID with tag stripped (shared)
- req_result_payload_o  out  RESULT_W  result payload (shared)
- cop_issue_valid_o  out  1
- cop_issue_ready_i  in  1
- cop_issue_id_o  out  SRC_W+ID_W  {src, id}
- cop_issue_payload_o  out  ISSUE_W
- cop_issue_accept_i  in  1
- cop_commit_valid_o  out  1
- cop_commit_id_o  out  SRC_W+ID_W
- cop_commit_kill_o  out  1
- cop_result_valid_i  in  1
- cop_result_ready_o  out  1
- cop_result_id_i  in  SRC_W+ID_W
- cop_result_payload_i  in  RESULT_W

Behaviour:
- Reset (rst_i high, asynchronous):
  - All valid/ready outputs 0, grant pointer 0, arbiter in IDLE.
  - Outstanding counters 0, commit FIFOs empty.
  - Reset mid-operation discards in-flight state; the coprocessor is reset alongside.
- Eligibility: core i is eligible when req_issue_valid_i[i]=1 and out_cnt[i] < MAX_OUT.
- Issue arbiter FSM, two states:
  - IDLE: if any core is eligible, grant the first eligible core at or after rr_ptr (wrapping) and go to HOLD in the same cycle. cop_issue_valid_o is combinational from the grant.
  - HOLD: grant frozen; cop_issue_* driven from the granted core; valid must not drop.
  - On cop_issue_ready_i=1: req_issue_ready_o[g]=1 and req_issue_accept_o[g]=cop_issue_accept_i. All other cores see ready=0, accept=0.
  - After the handshake: rr_ptr = g+1 mod NUM_REQ, next state IDLE.
  - Single-cycle issue is allowed: IDLE grant plus ready in the same cycle completes without entering HOLD.
  - A core deasserting valid while held is a protocol violation; assert it in simulation.
- Outstanding counters:
  - out_cnt[i] +1 on an accepted issue (handshake with accept=1).
  - out_cnt[i] −1 on a result handshake routed to i.
  - out_cnt[i] −1 on a commit with kill=1 popped for i.
  - Simultaneous increment and decrement leave the count unchanged. Underflow must never occur; assert it.
  - A rejected issue (accept=0) does not count.
- Commit path:
  - A commit is pushed into FIFO i whenever req_commit_valid_i[i]=1.
  - FIFO full on push is impossible by construction; assert it.
  - Each cycle at most one FIFO is popped, round-robin with its own pointer, driving cop_commit_valid_o=1 with id {i, id} and the kill flag. Commit latency is 1 cycle minimum (registered FIFO output).
  - A push and a pop on the same FIFO in one cycle are both honoured.
- Result path:
  - src = cop_result_id_i[top SRC_W bits].
  - req_result_valid_o[src] = cop_result_valid_i; all other cores 0.
  - cop_result_ready_o = req_result_ready_i[src]; fully combinational, zero latency.
  - An out-of-range src (NUM_REQ not a power of two) gives ready=1 and drops the result; assert it.

Test Plan:
- Reset, then core0 issues id 3 with ready=1, accept=1 → cop_issue_id_o={0,3} the same cycle, req_issue_ready_o=01, out_cnt[0]=1.
- Core0 and core1 issue continuously with ready always 1 → grants alternate 0,1,0,1; each core stalls once it has 4 outstanding with no results returned.
- cop_issue_ready_i held low 5 cycles while core1 is granted → payload and ID stable, core0 receives no ready, grant unchanged until the handshake.
- Both cores commit in the same cycle (id 2, kill 0; id 5, kill 1) → two cop_commit pulses on consecutive cycles, {0,2} then {1,5} with kill=1, out_cnt[1] decremented.
- Coprocessor returns result id {1,7} while req_result_ready_i=10 → req_result_valid_o=10, req_result_id_o=7, handshake completes, out_cnt[1]−1. With req_result_ready_i=01 → cop_result_ready_o=0 and the result stalls.
- rst_i asserted during a HOLD with 3 outstanding → all outputs 0 immediately, counters 0, and a new issue is accepted in the first cycle after release.
